// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
// Holds the default widths and the skid-buffer state encoding.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_CTRL_W = 6;
   localparam int PIPE_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_t;

   // Number of beats held in a given state.
   function automatic logic [1:0] state_occupancy(input stage_state_t s);
      logic [1:0] occ;
      case (s)
         ST_HALF: occ = 2'd1;
         ST_FULL: occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage register: payload and control registers.
// Loading captures both; clearing zeroes only the control bits so an empty slot never carries live control.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_data <= '0;
         q_ctrl <= '0;
      end else if (load) begin
         q_data <= d_data;
         q_ctrl <= d_ctrl;
      end else if (clear) begin
         q_ctrl <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage with flush and a saturating stall counter.
// The main slot drives the outputs; the skid slot catches the beat accepted while downstream stalls.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int CNT_W  = PIPE_CNT_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_state_t      state;
   stage_state_t      state_nxt;
   logic              accept;
   logic              drain;
   logic              main_load;
   logic              main_clear;
   logic              skid_load;
   logic              skid_clear;
   logic [DATA_W-1:0] main_d_data;
   logic [CTRL_W-1:0] main_d_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // Flush overrides every handshake: everything held is dropped, including an incoming beat.
   always_comb begin
      state_nxt  = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         state_nxt  = ST_EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt = ST_HALF;
                  main_load = 1'b1;
               end
            end
            ST_HALF: begin
               if (accept && drain) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  state_nxt = ST_FULL;
                  skid_load = 1'b1;
               end else if (drain) begin
                  state_nxt  = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state_nxt  = ST_HALF;
                  main_load  = 1'b1;
                  skid_clear = 1'b1;
               end
            end
            default: begin
               state_nxt  = ST_EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   // When full, main refills from the skid slot so order is preserved.
   assign main_d_data = (state == ST_FULL) ? skid_data : in_data;
   assign main_d_ctrl = (state == ST_FULL) ? skid_ctrl : in_ctrl;

   // Handshake outputs are registered from the next state so in_ready has no path from out_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != ST_EMPTY);
         in_ready  <= (state_nxt != ST_FULL);
         occupancy <= state_occupancy(state_nxt);
      end
   end

   // Counts downstream back-pressure cycles; sticks at all-ones and survives flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_main_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load),
      .clear  (main_clear),
      .d_data (main_d_data),
      .d_ctrl (main_d_ctrl),
      .q_data (main_data),
      .q_ctrl (main_ctrl)
   );

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid_slot (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .q_data (skid_data),
      .q_ctrl (skid_ctrl)
   );

   assign out_data = main_data;
   assign out_ctrl = main_ctrl;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the datapath payload (PC, operands, immediate).
REQ-002 The block SHALL have parameter CTRL_W, default 6, width of the control payload (mem read/write, byte select, reg write, branch, load); it is zeroed on every bubble.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 The block SHALL have port in_ready, output, 1, stage can accept a beat.
REQ-008 The block SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W, upstream control bits.
REQ-010 The block SHALL have port flush, input, 1, synchronous kill of all held beats.
REQ-011 The block SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 The block SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-013 The block SHALL have port out_data, output, DATA_W, held payload.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W, held control; all-zero whenever out_valid=0.
REQ-015 The block SHALL have port occupancy, output, 2, number of held beats (0..2).
REQ-016 The block SHALL have port stall_cnt, output, CNT_W, saturating count of out_valid=1 && out_ready=0 cycles.

Function
REQ-017 The block SHALL accept a beat on a rising edge when in_valid=1 and in_ready=1, and SHALL drain one when out_valid=1 and out_ready=1.
REQ-018 The block SHALL be a 2-entry skid buffer (main slot drives outputs, skid slot behind it) with states EMPTY, HALF and FULL; occupancy is 0, 1 and 2 respectively.
REQ-019 From EMPTY, an accept SHALL move to HALF with main loaded, giving latency 1 cycle from in to out.
REQ-020 From HALF, accept without drain SHALL go to FULL with skid loaded; accept with drain SHALL stay HALF with main reloaded; drain only SHALL go to EMPTY.
REQ-021 From FULL, drain SHALL go to HALF with main <= skid; without drain, the state SHALL hold.
REQ-022 in_ready SHALL be 1 in EMPTY and HALF and 0 in FULL, and SHALL be derived only from registered state, with no combinational path from out_ready.
REQ-023 Beat order SHALL be strictly preserved; no beat is duplicated or lost except by flush.
REQ-024 The ctrl register of any slot becoming empty SHALL be cleared to 0; data registers retain their last value.
REQ-025 flush=1 SHALL take priority over accept and drain: next state EMPTY and both ctrl slots zero; an in_valid beat in the flush cycle is discarded; a downstream handshake in the flush cycle still counts as consumed.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 && out_ready=0, saturate at 2^CNT_W-1, and never wrap.
REQ-027 Flush SHALL NOT clear stall_cnt.

Reset
REQ-028 While reset=0, the block SHALL hold the state at EMPTY, out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0 and in_ready=0.
REQ-029 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all held beats immediately, without waiting for a clock.

Structure
REQ-031 The state encoding (EMPTY/HALF/FULL) SHALL be defined in the shared package pipe_pkg.
REQ-032 The default widths DATA_W, CTRL_W and CNT_W SHALL be defined in the shared package pipe_pkg.
REQ-033 One slot (DATA_W + CTRL_W registers with load and clear-ctrl) SHALL be the sub-module pipe_slot, instantiated twice.

Verification
REQ-034 Scenario: reset low then high, in_valid=1, in_data=0x1234_5678, in_ctrl=6'b001001, out_ready=1 -> first edge in_ready=1; next edge out_valid=1, out_data=0x12345678, out_ctrl=6'b001001.
REQ-035 Scenario: stream beats 1,2,3,4 with out_ready held 0 -> occupancy 1 then 2; in_ready=0 after beat 2; beats 3 and 4 stalled; stall_cnt counts up from 1.
REQ-036 Scenario: from FULL (beats A, B), raise out_ready for 2 cycles -> A then B emitted in order; occupancy 1 then 0; out_ctrl=0 afterwards.
REQ-037 Scenario: flush=1 in FULL with in_valid=1 (beat C) -> next cycle occupancy=0, out_valid=0, out_ctrl=0; C never appears.
REQ-038 Scenario: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15, held with no wrap.
REQ-039 Scenario: random in_valid/out_ready for 10k cycles against a FIFO model -> output sequence equals input sequence and in_ready is never 1 in FULL.
